// File: rtl/obstacle_scheduler.sv
// Obstacle slot scheduler + IDLE/RUN/OVER game FSM; all outputs registered, 1-clk latency from tick/START/collide.
// Optional speed ramp compiled in with `define OBSTACLE_RAMP_EN (otherwise speed stays at SPEED_INIT).
module obstacle_scheduler #(
  parameter int NUM_SLOTS   = 3,
  parameter int SPAN        = 700,
  parameter int MIN_GAP     = 120,
  parameter int SPEED_INIT  = 4,
  parameter int SPEED_MAX   = 12,
  parameter int RAMP_FRAMES = 600
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   fresh,
  input  logic                   collide,
  output logic                   game_status,
  output logic [3:0]             speed,
  output logic [NUM_SLOTS-1:0]   active,
  output logic [10*NUM_SLOTS-1:0] pos_bus,
  output logic [7:0]             passed
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [10:0] SPAN_W      = 11'(SPAN);
  localparam logic [9:0]  MIN_GAP_W   = 10'(MIN_GAP);
  localparam logic [3:0]  SPEED_INIT_W = 4'(SPEED_INIT);
  localparam logic [3:0]  SPEED_MAX_W  = 4'(SPEED_MAX);
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  state_t               state_q, state_d;
  logic                 fresh_q;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [3:0]           speed_q, speed_d;
  logic [NUM_SLOTS-1:0] act_q, act_d;
  logic [9:0]           pos_q [NUM_SLOTS];
  logic [9:0]           pos_d [NUM_SLOTS];
  logic [7:0]           passed_q, passed_d;
  logic [9:0]           gap_q, gap_d;
  logic [9:0]           target_q, target_d;

`ifdef OBSTACLE_RAMP_EN
  localparam int FW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(RAMP_FRAMES - 1);
  logic [FW-1:0] frame_q, frame_d;
`endif

  logic        tick;
  logic        init_game;
  logic        run_tick;
  logic        spawned;
  logic [10:0] sum;
  logic [7:0]  n_ret;
  logic [8:0]  psum;
  logic [10:0] gsum;

  assign tick = fresh_q & ~fresh;

  always_comb begin
    state_d   = state_q;
    init_game = 1'b0;
    run_tick  = 1'b0;
    case (state_q)
      IDLE: if (START) begin state_d = RUN; init_game = 1'b1; end
      RUN: begin
        if (collide) state_d = OVER;
        else if (tick) run_tick = 1'b1;
      end
      OVER: if (START) begin state_d = RUN; init_game = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    speed_d  = speed_q;
    act_d    = act_q;
    pos_d    = pos_q;
    passed_d = passed_q;
    gap_d    = gap_q;
    target_d = target_q;
    spawned  = 1'b0;
    sum      = '0;
    n_ret    = '0;
    psum     = '0;
    gsum     = '0;
`ifdef OBSTACLE_RAMP_EN
    frame_d  = frame_q;
`endif
    if (init_game) begin
      act_d    = '0;
      for (int i = 0; i < NUM_SLOTS; i++) pos_d[i] = '0;
      speed_d  = SPEED_INIT_W;
      passed_d = '0;
      gap_d    = MIN_GAP_W;
      target_d = MIN_GAP_W;
`ifdef OBSTACLE_RAMP_EN
      frame_d  = '0;
`endif
    end else if (run_tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (act_q[i]) begin
          sum = {1'b0, pos_q[i]} + {7'd0, speed_q};
          if (sum >= SPAN_W) begin
            act_d[i] = 1'b0;
            pos_d[i] = '0;
            n_ret    = n_ret + 8'd1;
          end else begin
            pos_d[i] = sum[9:0];
          end
        end
      end
      psum     = {1'b0, passed_q} + {1'b0, n_ret};
      passed_d = psum[8] ? 8'hFF : psum[7:0];
      // Spawn sees the post-advance mask, so a slot retiring this tick can be reused.
      if (gap_q >= target_q) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (!spawned && !act_d[i]) begin
            spawned  = 1'b1;
            act_d[i] = 1'b1;
            pos_d[i] = '0;
          end
        end
      end
      if (spawned) begin
        gap_d    = '0;
        target_d = MIN_GAP_W + {3'd0, lfsr_q[6:0]};
      end else begin
        gsum  = {1'b0, gap_q} + {7'd0, speed_q};
        gap_d = gsum[10] ? 10'h3FF : gsum[9:0];
      end
`ifdef OBSTACLE_RAMP_EN
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        if (speed_q < SPEED_MAX_W) speed_d = speed_q + 4'd1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= IDLE;
      fresh_q  <= 1'b1;
      lfsr_q   <= LFSR_SEED;
      speed_q  <= SPEED_INIT_W;
      act_q    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) pos_q[i] <= '0;
      passed_q <= '0;
      gap_q    <= MIN_GAP_W;
      target_q <= MIN_GAP_W;
`ifdef OBSTACLE_RAMP_EN
      frame_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      fresh_q  <= fresh;
      lfsr_q   <= lfsr_d;
      speed_q  <= speed_d;
      act_q    <= act_d;
      pos_q    <= pos_d;
      passed_q <= passed_d;
      gap_q    <= gap_d;
      target_q <= target_d;
`ifdef OBSTACLE_RAMP_EN
      frame_q  <= frame_d;
`endif
    end
  end

  assign game_status = (state_q == RUN);
  assign speed       = speed_q;
  assign active      = act_q;
  assign passed      = passed_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pos
    assign pos_bus[10*g +: 10] = pos_q[g];
  end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Frame-rate scheduler for the cactus obstacle layer. Owns a small pool of obstacle slots and decides when each is spawned, scrolled and retired. Also runs the game state machine (idle / running / over) and the scroll-speed ramp. Sits between the VGA frame strobe and the per-slot cactus renderers: each renderer takes one slot's position, its active bit, and the shared speed.

## Interface
Parameters:
- NUM_SLOTS, 3, number of concurrent obstacle slots (1..4)
- SPAN, 700, scroll length in pixels (screen width 640 + sprite width 60); a slot retires at or beyond SPAN
- MIN_GAP, 120, minimum pixel spacing between consecutive spawns
- SPEED_INIT, 4, scroll speed in pixels/frame after START
- SPEED_MAX, 12, speed saturation value (must be at most 15)
- RAMP_FRAMES, 600, frames per +1 speed step

Ports:
- clk  in  1  system clock, driven from clkdiv[0]
- RESET  in  1  synchronous, active-high reset
- START  in  1  level; starts or restarts a game
- fresh  in  1  frame strobe; a falling edge marks one frame tick
- collide  in  1  level, from collision detect; ends the game
- game_status  out  1  1 while in RUN
- speed  out  4  current scroll speed
- active  out  NUM_SLOTS  per-slot active mask
- pos_bus  out  10*NUM_SLOTS  slot i position at bits [10i+9:10i]
- passed  out  8  count of retired obstacles, saturates at 255

## Operation
- FSM states: IDLE, RUN, OVER.
  - RESET from any state: go to IDLE.
  - IDLE + START: go to RUN.
  - RUN + collide: go to OVER.
  - OVER + START: go to RUN.
  - START in RUN is ignored.
- Game init, applied on IDLE->RUN and OVER->RUN:
  - all slots inactive, all positions 0
  - speed=SPEED_INIT, passed=0, frame counter=0
  - gap_cnt=MIN_GAP, target_gap=MIN_GAP, so the first tick spawns immediately.
- Frame tick: fresh is registered into fresh_d. tick = fresh_d & ~fresh. Ticks have effect only in RUN.
- On each tick in RUN, in this order:
  1. Advance: for each active slot, sum = pos + speed in an 11-bit intermediate.
     - If sum >= SPAN: slot goes inactive, pos=0, passed += 1 (saturating; +2 if two slots retire together).
     - Otherwise pos = sum.
  2. Spawn: if gap_cnt >= target_gap and a slot is free after step 1, spawn into the lowest-index free slot.
     - The new slot gets pos=0 and is not advanced on its spawn tick.
     - gap_cnt=0; target_gap = MIN_GAP + lfsr[6:0].
  3. If no spawn happened: gap_cnt += speed, saturating at 1023. When no slot is free, the spawn is deferred to the first tick with a free slot.
  4. Speed ramp, under the macro: the frame counter increments. At RAMP_FRAMES-1 it wraps to 0 and speed = min(speed+1, SPEED_MAX).
- OVER: positions, active, speed and passed are frozen so the final scene stays displayed. Ticks are ignored.
- IDLE: active=0 and all positions 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Seeded to 16'hACE1 on RESET. Advances every clk cycle in every state, so spacing depends on player timing.

## Timing
- All outputs are registered. Reset values:
  - game_status=0, speed=SPEED_INIT, active=0, pos_bus=0, passed=0
  - FSM=IDLE, fresh_d=1.
- Tick updates commit at the first clk edge that samples fresh=0 after sampling fresh=1 at the previous edge. Latency is 1 clk.
- game_status changes at the edge that samples START or collide; latency is 1 clk.
- Simultaneous events:
  - RESET beats everything.
  - collide in the same cycle as a tick: go to OVER, no advance.
  - START in the same cycle as a tick in OVER: init only, the tick is discarded.
- A slot retiring and a spawn on the same tick may reuse the same slot.
- RESET mid-game clears everything within one clk; START is then required.

## Configuration
- OBSTACLE_RAMP_EN
  - Defined: the frame counter and speed ramp exist as described.
  - Undefined: no frame counter; speed is held at SPEED_INIT for the whole game.

## Test plan
- RESET, then START, then 1 tick -> game_status=1, active=3'b001, pos0=0, speed=4, passed=0.
- Continue with no collide -> pos0=4k after k further ticks. At k=175 slot0 retires: active bit0=0 (unless respawned), passed=1.
- Force collide in the same cycle as a tick at pos0=40 -> OVER, pos0 stays 40 across 10 further ticks, game_status=0. START then 1 tick -> fresh game, active=3'b001, pos0=0.
- NUM_SLOTS=1, hold run -> no second spawn while slot0 is active; respawn occurs on the same tick slot0 retires, and pos stays 0 on that tick.
- With OBSTACLE_RAMP_EN and RAMP_FRAMES=4 -> speed 4,5,...,12 after 4,8,...,32 ticks, then holds at 12. Without the macro, speed stays 4.
- Assert RESET and START together in RUN -> IDLE, active=0, speed=4, lfsr=16'hACE1.
